// File: rtl/mem_router.sv
// Address decoder and wait-state sequencer between the 8088 core bus and the
// on-chip block RAMs, with write protection and a sticky fault register.
module mem_router #(
  parameter int                   AW       = 20,
  parameter int                   DW       = 8,
  parameter int                   NREG     = 3,
  parameter logic [NREG*AW-1:0]   REG_BASE = {20'hFE000, 20'hB8000, 20'h00000},
  parameter logic [NREG*AW-1:0]   REG_MASK = {20'hFE000, 20'hFC000, 20'hFC000},
  parameter logic [NREG*4-1:0]    REG_WAIT = {4'd0, 4'd1, 4'd0},
  parameter logic [NREG-1:0]      REG_RO   = 3'b100,
  parameter logic [DW-1:0]        OPEN_BUS = 8'hFF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AW-1:0]        cpu_address,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [DW-1:0]        cpu_out,
  output logic [DW-1:0]        cpu_in,
  output logic                 cpu_ready,
  output logic [AW-1:0]        mem_address,
  output logic [DW-1:0]        mem_data,
  output logic [NREG-1:0]      mem_we,
  input  logic [NREG*DW-1:0]   mem_q,
  output logic                 fault,
  output logic [AW-1:0]        fault_address,
  input  logic                 fault_clear
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg;
  logic            we_reg;
  logic [DW-1:0]   data_reg;
  logic [IW-1:0]   idx_reg;
  logic [3:0]      cnt_reg;
  logic            first_reg;
  logic [DW-1:0]   cpu_in_reg;
  logic            fault_reg;
  logic [AW-1:0]   fault_addr_reg;

  logic [NREG-1:0] hit;
  logic            hit_any;
  logic [IW-1:0]   hit_idx;
  logic [3:0]      wait_sel;
  logic            ro_sel;
  logic            accept;
  logic            fault_set;
  logic            we_fire;
  logic [DW-1:0]   q_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      assign hit[gi]    = (cpu_address & REG_MASK[gi*AW +: AW]) == REG_BASE[gi*AW +: AW];
      assign mem_we[gi] = we_fire && (idx_reg == IW'(gi)) && !REG_RO[gi];
    end
  endgenerate

  // Scan downwards so the lowest matching region index is the one that sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign wait_sel  = REG_WAIT[hit_idx*4 +: 4];
  assign ro_sel    = REG_RO[hit_idx];
  assign q_sel     = mem_q[idx_reg*DW +: DW];
  assign accept    = (state_reg == IDLE) && cpu_req;
  assign fault_set = accept && (!hit_any || (cpu_we && ro_sel));

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cpu_req) state_next = hit_any ? ACCESS : DONE;
      ACCESS:  if (cnt_reg == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The RAM read is launched from the raw CPU address during the accept cycle.
  always_comb begin
    cpu_ready   = 1'b0;
    mem_address = addr_reg;
    we_fire     = 1'b0;
    case (state_reg)
      IDLE:    mem_address = cpu_address;
      ACCESS:  we_fire     = first_reg && we_reg && !reset;
      DONE:    cpu_ready   = !reset;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      data_reg   <= '0;
      idx_reg    <= '0;
      cnt_reg    <= 4'd0;
      first_reg  <= 1'b0;
      cpu_in_reg <= OPEN_BUS;
    end else begin
      first_reg <= accept;
      if (accept) begin
        addr_reg <= cpu_address;
        we_reg   <= cpu_we;
        data_reg <= cpu_out;
        idx_reg  <= hit_idx;
        cnt_reg  <= hit_any ? wait_sel : 4'd0;
        if (!hit_any) cpu_in_reg <= OPEN_BUS;
      end else if (state_reg == ACCESS) begin
        if (cnt_reg != 4'd0)  cnt_reg    <= cnt_reg - 4'd1;
        else if (!we_reg)     cpu_in_reg <= q_sel;
      end
    end
  end

  // A fault arriving together with a clear takes precedence over the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
    end else if (fault_set) begin
      fault_reg <= 1'b1;
      if (!fault_reg || fault_clear) fault_addr_reg <= cpu_address;
    end else if (fault_clear) begin
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
    end
  end

  assign cpu_in        = cpu_in_reg;
  assign mem_data      = data_reg;
  assign fault         = fault_reg;
  assign fault_address = fault_addr_reg;

endmodule

// File: tb/tb_mem_router.sv
// Scoreboard bench for mem_router: directed scenarios plus random traffic,
// checked against an address-level model of the memory map.
module tb_mem_router;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam int NREG = 3;
  localparam logic [19:0] BASE_T [3] = '{20'h00000, 20'hB8000, 20'hFE000};
  localparam logic [19:0] MASK_T [3] = '{20'hFC000, 20'hFC000, 20'hFE000};
  localparam int          WAIT_T [3] = '{0, 1, 0};
  localparam bit          RO_T   [3] = '{1'b0, 1'b0, 1'b1};

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [AW-1:0]       cpu_address = '0;
  logic                cpu_req = 1'b0;
  logic                cpu_we = 1'b0;
  logic [DW-1:0]       cpu_out = '0;
  logic [DW-1:0]       cpu_in;
  logic                cpu_ready;
  logic [AW-1:0]       mem_address;
  logic [DW-1:0]       mem_data;
  logic [NREG-1:0]     mem_we;
  logic [NREG*DW-1:0]  mem_q = '0;
  logic                fault;
  logic [AW-1:0]       fault_address;
  logic                fault_clear = 1'b0;

  always #5 clock = ~clock;

  mem_router dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_out(cpu_out),
    .cpu_in(cpu_in), .cpu_ready(cpu_ready),
    .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .fault(fault), .fault_address(fault_address), .fault_clear(fault_clear)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit hold_mode = 1'b0;
  logic [7:0] seed = 8'h00;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] init_byte(input int r, input logic [19:0] off);
    if (r == 0 && off == 20'h00123) return 8'h5A;
    return 8'(r * 67 + int'(off) * 29 + int'(off >> 4)) ^ seed;
  endfunction

  // Block RAMs seen by the router: synchronous read, one cycle of latency.
  logic [7:0] ram [3][16384];
  bit         wv  [3][16384];
  always @(posedge clock) begin : env_ram
    logic [19:0] o;
    for (int i = 0; i < 3; i++) begin
      o = mem_address & ~MASK_T[i];
      mem_q[i*DW +: DW] <= wv[i][o[13:0]] ? ram[i][o[13:0]] : init_byte(i, o);
      if (mem_we[i]) begin
        ram[i][o[13:0]] <= mem_data;
        wv[i][o[13:0]]  <= 1'b1;
      end
    end
  end

  // Reference model: contents keyed by CPU address, fault state, last read value.
  logic [7:0]  mdl [logic [19:0]];
  bit          mf;
  logic [19:0] mfa;
  logic [7:0]  mlast;

  function automatic int decode(input logic [19:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & MASK_T[i]) == BASE_T[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] mdl_rd(input int r, input logic [19:0] a);
    if (mdl.exists(a)) return mdl[a];
    return init_byte(r, a & ~MASK_T[r]);
  endfunction

  typedef struct {
    logic [7:0]  data;
    int          lat;
    logic [2:0]  we;
    logic [7:0]  wdata;
    bit          f;
    logic [19:0] fa;
    int          acc;
  } exp_t;
  exp_t sbq [$];

  // Monitor: pops one expectation per cpu_ready and compares.
  logic [2:0] we_seen = '0;
  int         we_cyc = 0;
  logic [7:0] we_data = '0;
  always @(negedge clock) begin : monitor
    exp_t e;
    cyc++;
    if (mem_we != 3'b000) begin
      we_seen = mem_we;
      we_cyc  = cyc;
      we_data = mem_data;
    end
    if (cpu_ready && !hold_mode) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("cpu_in", cpu_in, e.data);
        chk("latency", cyc - e.acc, e.lat);
        chk("mem_we", we_seen, e.we);
        if (e.we != 3'b000) begin
          chk("we_cycle", we_cyc - e.acc, 1);
          chk("mem_data", we_data, e.wdata);
        end
        chk("fault", fault, e.f);
        chk("fault_address", fault_address, e.fa);
      end
      we_seen = '0;
      done_cnt++;
    end
  end

  task automatic access(input logic [19:0] a, input bit we, input logic [7:0] d, input bit clr);
    exp_t e;
    int r, target;
    bit fev;
    bit got;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_address = a; cpu_we = we; cpu_out = d; fault_clear = clr;
    r = decode(a);
    e.acc = cyc + 1; e.we = '0; e.wdata = '0; fev = 1'b0;
    if (r < 0) begin
      e.lat = 1; mlast = 8'hFF; fev = 1'b1;
    end else begin
      e.lat = WAIT_T[r] + 2;
      if (we) begin
        if (RO_T[r]) fev = 1'b1;
        else begin mdl[a] = d; e.we = 3'(1 << r); e.wdata = d; end
      end else mlast = mdl_rd(r, a);
    end
    if (fev) begin
      if (!mf || clr) mfa = a;
      mf = 1'b1;
    end else if (clr) begin
      mf = 1'b0; mfa = '0;
    end
    e.data = mlast; e.f = mf; e.fa = mfa;
    target = done_cnt + 1;
    sbq.push_back(e);
    $display("txn addr=%05h we=%0d wdata=%02h clr=%0d region=%0d exp_in=%02h", a, we, d, clr, r, mlast);
    @(posedge clock); #1;
    cpu_req = 1'b0; fault_clear = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clock);
      if (done_cnt >= target) got = 1'b1;
    end
    if (!got) begin
      chk("ready_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  task automatic clear_alone();
    @(posedge clock); #1; fault_clear = 1'b1;
    @(posedge clock); #1; fault_clear = 1'b0;
    mf = 1'b0; mfa = '0;
    @(negedge clock);
    chk("clear_fault", fault, 32'd0);
    chk("clear_fault_address", fault_address, 32'd0);
    $display("txn fault_clear alone");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [19:0] a;
    int sel, last_rdy, nrdy, hc;
    seed = 8'($urandom);
    mf = 1'b0; mfa = '0; mlast = 8'hFF;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", cpu_ready, 32'd0);
    chk("rst_cpu_in", cpu_in, 32'hFF);
    chk("rst_fault", fault, 32'd0);
    chk("rst_fault_address", fault_address, 32'd0);
    chk("rst_mem_we", mem_we, 32'd0);

    access(20'h00123, 1'b0, 8'h00, 1'b0);
    access(20'hB8010, 1'b1, 8'h3C, 1'b0);
    access(20'hB8010, 1'b0, 8'h00, 1'b0);
    access(20'hFE005, 1'b1, 8'h11, 1'b0);
    access(20'hFE005, 1'b0, 8'h00, 1'b0);
    clear_alone();
    access(20'h40000, 1'b0, 8'h00, 1'b0);
    access(20'h50000, 1'b0, 8'h00, 1'b0);
    access(20'h60000, 1'b0, 8'h00, 1'b1);
    clear_alone();

    // Reset during the first access cycle of a write.
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_address = 20'hB8020; cpu_we = 1'b1; cpu_out = 8'h77;
    @(posedge clock); #1;
    cpu_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("rstmid_mem_we", mem_we, 32'd0);
    chk("rstmid_ready", cpu_ready, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    mf = 1'b0; mfa = '0; mlast = 8'hFF;
    $display("txn reset mid-access addr=b8020");
    repeat (6) @(negedge clock);
    chk("rstmid_cpu_in", cpu_in, 32'hFF);
    chk("rstmid_fault", fault, 32'd0);
    access(20'hB8020, 1'b0, 8'h00, 1'b0);

    // Held request: region 1 read repeats every W+3 = 4 cycles.
    hold_mode = 1'b1;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_address = 20'hB8010; cpu_we = 1'b0;
    last_rdy = -1; nrdy = 0;
    for (hc = 0; hc < 30; hc++) begin
      @(negedge clock);
      if (cpu_ready) begin
        if (last_rdy >= 0) chk("hold_interval", hc - last_rdy, 4);
        chk("hold_data", cpu_in, mdl_rd(1, 20'hB8010));
        last_rdy = hc;
        nrdy++;
      end
    end
    chk("hold_count_ge7", (nrdy >= 7), 32'd1);
    @(posedge clock); #1 cpu_req = 1'b0;
    repeat (6) @(posedge clock);
    hold_mode = 1'b0;
    mlast = mdl_rd(1, 20'hB8010);
    $display("txn held request readies=%0d", nrdy);

    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 3);
      if (sel < 3) begin
        a = BASE_T[sel] | 20'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a = BASE_T[sel] | (20'($urandom) & ~MASK_T[sel]);
      end else begin
        a = 20'($urandom);
        while (decode(a) >= 0) a = 20'($urandom);
      end
      access(a, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 19) == 0) clear_alone();
    end

    repeat (4) @(posedge clock);
    chk("queue_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_router.md
# mem_router

Parametrised memory router for the 8088 core bus. It decodes a 20-bit CPU address into up to four on-chip memory regions. It inserts per-region wait states and returns read data through a registered ready handshake. Write-protected regions (BIOS) are enforced, and unmapped or illegal accesses are logged in a sticky fault register. It sits between `core` and the block RAMs (data, CGA, BIOS) and replaces the combinational `casex` decode in the board top level.

## Interface

Parameters:
- `AW`, 20: address width.
- `DW`, 8: data width.
- `NREG`, 3: number of regions, 1..4.
- `REG_BASE`, {20'hFE000, 20'hB8000, 20'h00000}: packed `NREG*AW`; region i base in slice i.
- `REG_MASK`, {20'hFE000, 20'hFC000, 20'hFC000}: packed `NREG*AW`. Region i hits when `(addr & mask_i) == base_i`.
- `REG_WAIT`, {4'd0, 4'd1, 4'd0}: packed `NREG*4`; extra wait cycles per region, 0..15.
- `REG_RO`, 3'b100: bit i set means region i is read-only.
- `OPEN_BUS`, 8'hFF: read value for unmapped addresses.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `cpu_address` in AW: CPU address, sampled at accept.
- `cpu_req` in 1: access request, level.
- `cpu_we` in 1: 1 = write, sampled at accept.
- `cpu_out` in DW: write data, sampled at accept.
- `cpu_in` out DW: read data, registered.
- `cpu_ready` out 1: one-cycle completion strobe.
- `mem_address` out AW: shared address to all regions.
- `mem_data` out DW: shared write data, latched.
- `mem_we` out NREG: per-region write strobe.
- `mem_q` in NREG*DW: per-region synchronous read data with 1-cycle latency.
- `fault` out 1: sticky fault flag.
- `fault_address` out AW: address of the first fault since the last clear.
- `fault_clear` in 1: clears `fault` and `fault_address`.

## Operation

- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - `mem_address = cpu_address`, combinational, so the RAM read starts in the accept cycle.
  - If `cpu_req` = 1: accept. Latch address, we, data, the hit index and the wait count.
  - Decode priority: lowest matching region index wins.
  - Hit: go to ACCESS.
  - No hit: go to DONE, load `cpu_in` with OPEN_BUS and raise the fault.
- **ACCESS**
  - `mem_address` = latched address.
  - Lasts `REG_WAIT[i]+1` cycles, tracked by a down-counter.
  - `mem_we[i]` = 1 only in the first ACCESS cycle, and only if latched we = 1 and `REG_RO[i]` = 0. All other `mem_we` bits stay 0.
  - A write to an RO region follows normal timing, issues no strobe and raises the fault.
  - At the end of the last ACCESS cycle, `cpu_in <= mem_q[i]` for reads only; writes leave `cpu_in` unchanged. Then go to DONE.
- **DONE**
  - `cpu_ready` = 1 for exactly this cycle, then go to IDLE.
  - `cpu_req` is ignored in ACCESS and DONE.
- **Fault register**
  - Set on an unmapped access (read or write) or an RO write.
  - `fault_address` is loaded only when `fault` was 0.
  - `fault_clear` clears both. If clear and a new fault occur in the same cycle, the new fault wins: `fault` = 1 with the new address.
- **Reset**
  - State IDLE, `cpu_ready` = 0, `cpu_in` = OPEN_BUS, `fault` = 0, `fault_address` = 0, counter = 0.
  - `mem_we` is forced to 0 in any cycle where `reset` = 1.
  - A reset mid-access aborts it: no ready, no strobe.

## Timing

- Accept cycle T (IDLE with `cpu_req` high).
- Mapped access: ACCESS runs T+1 .. T+1+W. `cpu_ready` and valid `cpu_in` appear at T+2+W.
- Write strobe at T+1.
- Unmapped access: `cpu_ready` at T+1.
- Next accept is possible at the earliest in the cycle after DONE. Mapped throughput is one access per W+3 cycles.
- `cpu_in` holds its value until the next read completes.

## Test plan

- **Read, region 0, W=0:** preload RAM0[0x0123]=0x5A, req read 0x00123 at T → `cpu_ready`=1 at T+2, `cpu_in`=0x5A, `mem_we`=0 throughout.
- **Write then read, region 1, W=1:** write 0xB8010=0x3C → `mem_we`=3'b010 at T+1 only, `mem_data`=0x3C, ready at T+3. Readback returns 0x3C, ready at T+3.
- **RO write, region 2:** write 0xFE005=0x11 → `mem_we` stays 0, ready at T+2, `fault`=1, `fault_address`=0xFE005. A subsequent read of the location returns the original byte.
- **Unmapped read and fault stickiness:** read 0x40000 → ready at T+1, `cpu_in`=0xFF, `fault`=1, `fault_address`=0x40000. A second unmapped read of 0x50000 leaves `fault_address`=0x40000.
- **Fault clear collision:** `fault_clear` asserted in the same cycle as an unmapped access to 0x60000 is accepted → `fault`=1, `fault_address`=0x60000. A clear alone → `fault`=0, `fault_address`=0.
- **Reset mid-access and request hold:** a region-1 write is accepted and `reset` is asserted in T+1 → `mem_we`=0, no `cpu_ready`, `cpu_in`=0xFF. Holding `cpu_req` high continuously gives exactly one `cpu_ready` per W+3 cycles.
